// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
// Arbitrates exception, cache-miss, mul/div and load-use hazards into stage enables/flushes.
module pipe_hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_RS,
    input  logic [4:0]  ID_RT,
    input  logic [4:0]  EX_RD,
    input  logic        EX_DMRd,
    input  logic        EX_start,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic        MEM_Exception,
    input  logic        MEM_eret_flush,
    output logic        PCWr,
    output logic        IF_IDWr,
    output logic        ID_EXWr,
    output logic        EX_MEMWr,
    output logic        MEM_WBWr,
    output logic        IF_Flush,
    output logic        ID_Flush,
    output logic        EX_Flush,
    output logic        MEM_Flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] md_cnt;
    logic             exc;
    logic             cache_stall;
    logic             load_use;

    assign exc         = MEM_Exception | MEM_eret_flush;
    assign cache_stall = icache_stall | dcache_stall;
    assign load_use    = EX_DMRd && (EX_RD != 5'd0) && ((EX_RD == ID_RS) || (EX_RD == ID_RT));

    always_comb begin
        PCWr      = 1'b1;
        IF_IDWr   = 1'b1;
        ID_EXWr   = 1'b1;
        EX_MEMWr  = 1'b1;
        MEM_WBWr  = 1'b1;
        IF_Flush  = 1'b0;
        ID_Flush  = 1'b0;
        EX_Flush  = 1'b0;
        MEM_Flush = 1'b0;
        md_done   = 1'b0;
        if (exc) begin
            IF_Flush  = 1'b1;
            ID_Flush  = 1'b1;
            EX_Flush  = 1'b1;
            MEM_Flush = 1'b1;
        end else if (cache_stall) begin
            PCWr     = 1'b0;
            IF_IDWr  = 1'b0;
            ID_EXWr  = 1'b0;
            EX_MEMWr = 1'b0;
            MEM_WBWr = 1'b0;
        end else if (state == MD_BUSY && md_cnt == '0) begin
            md_done = 1'b1;
        end else if (state == MD_BUSY || EX_start) begin
            // EX holds the mul/div while a bubble drains into MEM
            PCWr     = 1'b0;
            IF_IDWr  = 1'b0;
            ID_EXWr  = 1'b0;
            EX_MEMWr = 1'b0;
            EX_Flush = 1'b1;
        end else if (load_use) begin
            PCWr     = 1'b0;
            IF_IDWr  = 1'b0;
            ID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            md_cnt       <= '0;
            md_busy      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!PCWr)
                stall_cycles <= stall_cycles + 32'd1;
            if (exc) begin
                state   <= RUN;
                md_busy <= 1'b0;
                md_cnt  <= '0;
            end else if (!cache_stall) begin
                if (state == MD_BUSY) begin
                    if (md_cnt == '0) begin
                        state   <= RUN;
                        md_busy <= 1'b0;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end else if (EX_start) begin
                    // start cycle counts as the first occupancy cycle
                    state   <= MD_BUSY;
                    md_busy <= 1'b1;
                    md_cnt  <= CNT_W'(MD_CYCLES - 2);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ID_RS = '0, ID_RT = '0, EX_RD = '0;
    logic        EX_DMRd = 0, EX_start = 0, icache_stall = 0, dcache_stall = 0;
    logic        MEM_Exception = 0, MEM_eret_flush = 0;
    logic        PCWr, IF_IDWr, ID_EXWr, EX_MEMWr, MEM_WBWr;
    logic        IF_Flush, ID_Flush, EX_Flush, MEM_Flush;
    logic        md_busy, md_done;
    logic [31:0] stall_cycles;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rem      = 0;
    logic [31:0] stall_m  = '0;

    pipe_hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .ID_RS(ID_RS), .ID_RT(ID_RT), .EX_RD(EX_RD),
        .EX_DMRd(EX_DMRd), .EX_start(EX_start),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .MEM_Exception(MEM_Exception), .MEM_eret_flush(MEM_eret_flush),
        .PCWr(PCWr), .IF_IDWr(IF_IDWr), .ID_EXWr(ID_EXWr), .EX_MEMWr(EX_MEMWr), .MEM_WBWr(MEM_WBWr),
        .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush), .MEM_Flush(MEM_Flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {PCWr, IF_IDWr, ID_EXWr, EX_MEMWr, MEM_WBWr, IF_Flush, ID_Flush, EX_Flush, MEM_Flush};
    endfunction

    // rem = EX occupancy cycles still owed by an in-flight mul/div, counting the current cycle
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic dmrd, input logic start, input logic ic, input logic dc,
                        input logic exc, input logic eret);
        logic [8:0] vec;
        logic       done;
        logic       lu;
        @(negedge clk);
        check("md_busy", 32'(md_busy), 32'(rem > 0));
        check("stall_cycles", stall_cycles, stall_m);
        ID_RS = rs; ID_RT = rt; EX_RD = rd; EX_DMRd = dmrd; EX_start = start;
        icache_stall = ic; dcache_stall = dc; MEM_Exception = exc; MEM_eret_flush = eret;
        #1;
        lu   = dmrd && rd != 0 && (rd == rs || rd == rt);
        vec  = 9'b11111_0000;
        done = 1'b0;
        if (exc || eret)        vec = 9'b11111_1111;
        else if (ic || dc)      vec = 9'b00000_0000;
        else if (rem > 1)       vec = 9'b00001_0010;
        else if (rem == 1)      done = 1'b1;
        else if (start)         vec = 9'b00001_0010;
        else if (lu)            vec = 9'b00111_0100;
        check("enables_flushes", 32'(dut_vec()), 32'(vec));
        check("md_done", 32'(md_done), 32'(done));
        if (exc || eret)        rem = 0;
        else if (ic || dc)      rem = rem;
        else if (rem > 1)       rem = rem - 1;
        else if (rem == 1)      rem = 0;
        else if (start)         rem = MD - 1;
        if (!vec[8]) stall_m = stall_m + 1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", 32'(md_busy), 32'd0);
        check("reset_done", 32'(md_done), 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        check("reset_vec", 32'(dut_vec()), 32'h1F0);
        @(negedge clk);
        rst = 1'b1;

        // load-use, then same with r0 destination
        step(5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 0, 0);
        step(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
        step(5'd0, 5'd2, 5'd0, 0, 0, 0, 0, 0, 0);
        // mul/div with start held through the done cycle
        for (int i = 0; i < MD; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // cache freeze mid mul/div
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < MD; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // exception abort mid mul/div
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // eret beats icache stall and a load-use match
        step(5'd3, 5'd3, 5'd3, 1, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // async reset between edges while busy
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        EX_start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", 32'(md_busy), 32'd0);
        check("async_rst_stall", stall_cycles, 32'd0);
        check("async_rst_vec", 32'(dut_vec()), 32'h1F0);
        check("async_rst_done", 32'(md_done), 32'd0);
        rem = 0;
        stall_m = '0;
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < 2000; n++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 29) == 0));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
